button_press_classifier: RTL

//   Consumes the synchronous one-cycle press/release strobes of the push-button debouncer.

---
 rtl/button_press_classifier.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/button_press_classifier.sv
// button_press_classifier: turns debounced press/release strobes into one-cycle
// short / long / double press pulses, with an optional auto-repeat pulse train.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN.
//   Defined:   repeat_press pulses every REPEAT_CYCLES while a long press is held.
//   Undefined: repeat_press is tied to 0.
//
// Strobes are registered on entry, so every decision uses the previous cycle's
// inputs. All outputs are registered.
module button_press_classifier #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned GAP_CYCLES    = 300,
  parameter int unsigned REPEAT_CYCLES = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_down,
  input  logic pb_up,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_WAIT2     = 3'd2;
  localparam logic [2:0] ST_PRESS2    = 3'd3;
  localparam logic [2:0] ST_LONG_HOLD = 3'd4;

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);

  logic             down_q, up_q;
  logic             down_evt, up_evt;
  logic [2:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             short_d, short_q;
  logic             long_d, long_q;
  logic             double_d, double_q;
  logic             busy_d, busy_q;

  // Simultaneous press and release is illegal upstream; treat it as no strobe.
  always_comb begin
    down_evt = down_q & ~up_q;
    up_evt   = up_q & ~down_q;
  end

  // Gesture FSM: edge strobes take priority over timeouts in the same cycle.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (down_evt) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (up_evt) begin
          state_d = ST_WAIT2;
        end else if (cnt_q == LONG_TERM) begin
          state_d = ST_LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (down_evt) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == GAP_TERM) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (up_evt) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end
      end
      ST_LONG_HOLD: begin
        if (up_evt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer only runs in the two timed states, so it can never wrap.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_PRESS1) || (state_q == ST_WAIT2))) begin
      cnt_d = cnt_q + 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Main state, timer, input and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      down_q   <= 1'b0;
      up_q     <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      down_q   <= pb_down;
      up_q     <= pb_up;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = busy_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt_cnt_d, rpt_cnt_q;
  logic             repeat_d, repeat_q;

  // Repeat timer restarts on entry to LONG_HOLD; a release at terminal count wins.
  always_comb begin
    rpt_cnt_d = '0;
    repeat_d  = 1'b0;
    if ((state_q == ST_LONG_HOLD) && (state_d == ST_LONG_HOLD)) begin
      if (rpt_cnt_q == RPT_TERM) begin
        repeat_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  // Repeat timer and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_press = repeat_q;
`else
  assign repeat_press = 1'b0;
`endif

endmodule
